sha2_logic_pipe: RTL and testbench

//  Elastic 2-stage pipelined SHA-2 logic-function unit. Computes Maj, Ch, Sigma0/1 or sigma0/1
//  on one word per cycle; WORD_WIDTH selects the SHA-256 or SHA-512 variant.

---
 rtl/sha2_logic_pipe.sv | 111 +++++++++++
 tb/tb_sha2_logic_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_logic_pipe.sv
// Two-stage elastic SHA-2 logic-function unit (Maj, Ch, Sigma0/1, sigma0/1) with a pass-through tag.
// Latency is 2 cycles. It holds up to 2 words, and in_ready drops when both stages are held by out_ready=0.
module sha2_logic_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [WORD_WIDTH-1:0] in_x,
  input  logic [WORD_WIDTH-1:0] in_y,
  input  logic [WORD_WIDTH-1:0] in_z,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_err
);

  localparam int  W    = WORD_WIDTH;
  localparam bit  WIDE = (W == 64);
  localparam int  S0A  = WIDE ? 28 : 2;
  localparam int  S0B  = WIDE ? 34 : 13;
  localparam int  S0C  = WIDE ? 39 : 22;
  localparam int  S1A  = WIDE ? 14 : 6;
  localparam int  S1B  = WIDE ? 18 : 11;
  localparam int  S1C  = WIDE ? 41 : 25;
  localparam int  L0A  = WIDE ? 1  : 7;
  localparam int  L0B  = WIDE ? 8  : 18;
  localparam int  L0S  = WIDE ? 7  : 3;
  localparam int  L1A  = WIDE ? 19 : 17;
  localparam int  L1B  = WIDE ? 61 : 19;
  localparam int  L1S  = WIDE ? 6  : 10;

  generate
    if (W != 32 && W != 64) begin : g_bad_width
      $error("sha2_logic_pipe: WORD_WIDTH must be 32 or 64");
    end
  endgenerate

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int n);
    return (v >> n) | (v << (W - n));
  endfunction

  logic                 s1_valid;
  logic [2:0]           s1_op;
  logic [W-1:0]         s1_x, s1_y, s1_z;
  logic [TAG_WIDTH-1:0] s1_tag;
  logic                 s1_adv, s2_adv;
  logic [W-1:0]         f_data;
  logic                 f_err;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    f_data = '0;
    f_err  = 1'b0;
    case (s1_op)
      3'd0: f_data = (s1_x & s1_y) ^ (s1_x & s1_z) ^ (s1_y & s1_z);
      3'd1: f_data = (s1_x & s1_y) ^ (~s1_x & s1_z);
      3'd2: f_data = rotr(s1_x, S0A) ^ rotr(s1_x, S0B) ^ rotr(s1_x, S0C);
      3'd3: f_data = rotr(s1_x, S1A) ^ rotr(s1_x, S1B) ^ rotr(s1_x, S1C);
      3'd4: f_data = rotr(s1_x, L0A) ^ rotr(s1_x, L0B) ^ (s1_x >> L0S);
      3'd5: f_data = rotr(s1_x, L1A) ^ rotr(s1_x, L1B) ^ (s1_x >> L1S);
      default: f_err = 1'b1;
    endcase
  end

  // Operand registers only load on an accepted transfer; a bubble just clears s1_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= in_op;
        s1_x   <= in_x;
        s1_y   <= in_y;
        s1_z   <= in_z;
        s1_tag <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= f_data;
        out_tag  <= s1_tag;
        out_err  <= f_err;
      end
    end
  end

endmodule

// File: tb/tb_sha2_logic_pipe.sv
// Bench for sha2_logic_pipe: 32- and 64-bit instances share one input stream; directed vectors,
// back-pressure, a random valid/ready run against a reference model, and reset mid-flight.
module tb_sha2_logic_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_x, in_y, in_z;
  logic [7:0]  in_tag;

  logic        rdy32, ov32, oe32, rdy64, ov64, oe64;
  logic [31:0] od32;
  logic [63:0] od64;
  logic [7:0]  ot32, ot64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha2_logic_pipe #(.WORD_WIDTH(32), .TAG_WIDTH(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
    .in_x(in_x[31:0]), .in_y(in_y[31:0]), .in_z(in_z[31:0]), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_tag(ot32), .out_err(oe32));

  sha2_logic_pipe #(.WORD_WIDTH(64), .TAG_WIDTH(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64), .in_op(in_op),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_tag(ot64), .out_err(oe64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] v, input int n, input int w);
    logic [127:0] t;
    if (w == 32) begin
      t = {64'd0, v[31:0], v[31:0]} >> n;
      return {32'd0, t[31:0]};
    end
    t = {v, v} >> n;
    return t[63:0];
  endfunction

  // Returns {err, data}; data is zero-extended for the 32-bit variant.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [63:0] xi,
                                        input logic [63:0] yi, input logic [63:0] zi, input int w);
    logic [63:0] m, x, y, z;
    m = (w == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    x = xi & m; y = yi & m; z = zi & m;
    case (op)
      3'd0: return {1'b0, (x & y) | (z & (x | y))};
      3'd1: return {1'b0, (x & y) | (~x & z & m)};
      3'd2: return (w == 32) ? {1'b0, rr(x, 2, w) ^ rr(x, 13, w) ^ rr(x, 22, w)}
                             : {1'b0, rr(x, 28, w) ^ rr(x, 34, w) ^ rr(x, 39, w)};
      3'd3: return (w == 32) ? {1'b0, rr(x, 6, w) ^ rr(x, 11, w) ^ rr(x, 25, w)}
                             : {1'b0, rr(x, 14, w) ^ rr(x, 18, w) ^ rr(x, 41, w)};
      3'd4: return (w == 32) ? {1'b0, rr(x, 7, w) ^ rr(x, 18, w) ^ (x >> 3)}
                             : {1'b0, rr(x, 1, w) ^ rr(x, 8, w) ^ (x >> 7)};
      3'd5: return (w == 32) ? {1'b0, rr(x, 17, w) ^ rr(x, 19, w) ^ (x >> 10)}
                             : {1'b0, rr(x, 19, w) ^ rr(x, 61, w) ^ (x >> 6)};
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  // Entered and left at posedge+1 with an empty pipe; checks exact 2-cycle latency.
  task automatic run_one(input string nm, input logic wide, input logic [2:0] op,
                         input logic [63:0] x, input logic [63:0] y, input logic [63:0] z,
                         input logic [7:0] tg, input logic [63:0] exp_d, input logic exp_e);
    in_op = op; in_x = x; in_y = y; in_z = z; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check({nm, "_in_ready"}, {63'd0, rdy32}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_valid_c1"}, {63'd0, wide ? ov64 : ov32}, 64'd0);
    @(posedge clk); #1;
    check({nm, "_valid_c2"}, {63'd0, wide ? ov64 : ov32}, 64'd1);
    check({nm, "_data"}, wide ? od64 : {32'd0, od32}, exp_d);
    check({nm, "_tag"}, {56'd0, wide ? ot64 : ot32}, {56'd0, tg});
    check({nm, "_err"}, {63'd0, wide ? oe64 : oe32}, {63'd0, exp_e});
  endtask

  typedef struct { logic [64:0] r32; logic [64:0] r64; logic [7:0] tag; } exp_t;

  initial begin : main
    exp_t        q[$];
    exp_t        e;
    int          sent, got, idx, recv;
    logic        hold, prev_stall;
    logic [31:0] pd32;
    logic [63:0] pd64;
    logic [7:0]  pt;
    localparam int NRAND = 4000;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, ov32}, 64'd0);
    check("rst_out_data", {32'd0, od32}, 64'd0);
    check("rst_out_tag", {56'd0, ot32}, 64'd0);
    check("rst_out_err", {63'd0, oe32}, 64'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, rdy32}, 64'd1);

    run_one("maj32", 1'b0, 3'd0, 64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 8'h11, 64'h3a6fe667, 1'b0);
    run_one("ch32",  1'b0, 3'd1, 64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 8'h12, 64'h1f85c98c, 1'b0);
    run_one("S0_32", 1'b0, 3'd2, 64'h6a09e667, 64'd0, 64'd0, 8'h13, 64'hce20b47e, 1'b0);
    run_one("S1_32", 1'b0, 3'd3, 64'h510e527f, 64'd0, 64'd0, 8'h14, 64'h3587272b, 1'b0);
    run_one("s0_32", 1'b0, 3'd4, 64'h00000001, 64'd0, 64'd0, 8'h15, 64'h02004000, 1'b0);
    run_one("s1_32", 1'b0, 3'd5, 64'h00000001, 64'd0, 64'd0, 8'h16, 64'h0000a000, 1'b0);
    run_one("op6_32", 1'b0, 3'd6, 64'hffffffff, 64'hffffffff, 64'hffffffff, 8'h17, 64'd0, 1'b1);
    run_one("maj64", 1'b1, 3'd0, '1, '1, 64'd0, 8'h21, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_one("op7_64", 1'b1, 3'd7, '1, '1, '1, 8'h22, 64'd0, 1'b1);
    run_one("s0_64", 1'b1, 3'd4, 64'h1, 64'd0, 64'd0, 8'h23, 64'h8100_0000_0000_0000, 1'b0);

    // Back-pressure: 5 tagged words, output stalled for 4 cycles once the unit is full.
    @(posedge clk); #1;
    out_ready = 1'b0; sent = 0; got = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_op = 3'd0; in_x = 64'(sent + 1); in_y = '1; in_z = '0;
      in_tag = 8'(sent + 1);
      #1;
      if (c < 2) check("bp_accept", {63'd0, rdy32}, 64'd1);
      else begin
        check("bp_refuse", {63'd0, rdy32}, 64'd0);
        check("bp_hold_valid", {63'd0, ov32}, 64'd1);
        check("bp_hold_tag", {56'd0, ot32}, 64'd1);
      end
      if (rdy32) sent++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid = (sent < 5); in_x = 64'(sent + 1); in_tag = 8'(sent + 1);
      #1;
      if (ov32) begin
        got++;
        check("bp_order_tag", {56'd0, ot32}, 64'(got));
        check("bp_data", {32'd0, od32}, 64'(got));
      end
      if (in_valid && rdy32) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_count", 64'(got), 64'd5);
    repeat (3) @(posedge clk);
    #1 check("bp_no_dup", {63'd0, ov32}, 64'd0);

    // Random valid/ready against the model, both widths in lockstep.
    idx = 0; recv = 0; hold = 1'b0; prev_stall = 1'b0;
    pd32 = '0; pd64 = '0; pt = '0;
    for (int cyc = 0; cyc < 60000 && recv < NRAND; cyc++) begin
      if (!hold) begin
        in_valid = (idx < NRAND) && ($urandom_range(0, 3) != 0);
        in_op = 3'($urandom_range(0, 7));
        in_x = {$urandom, $urandom}; in_y = {$urandom, $urandom}; in_z = {$urandom, $urandom};
        in_tag = 8'(idx);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        check("stall_valid", {63'd0, ov32}, 64'd1);
        check("stall_data32", {32'd0, od32}, {32'd0, pd32});
        check("stall_data64", od64, pd64);
        check("stall_tag", {56'd0, ot32}, {56'd0, pt});
      end
      if (ov32 && out_ready) begin
        if (q.size() == 0) check("rand_spurious_out", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          check("rand_data32", {32'd0, od32}, e.r32[63:0]);
          check("rand_err32", {63'd0, oe32}, {63'd0, e.r32[64]});
          check("rand_data64", od64, e.r64[63:0]);
          check("rand_err64", {63'd0, oe64}, {63'd0, e.r64[64]});
          check("rand_tag", {56'd0, ot32}, {56'd0, e.tag});
          check("rand_tag64", {56'd0, ot64}, {56'd0, e.tag});
          recv++;
        end
      end
      if (in_valid && rdy32) begin
        e.r32 = model(in_op, in_x, in_y, in_z, 32);
        e.r64 = model(in_op, in_x, in_y, in_z, 64);
        e.tag = in_tag;
        q.push_back(e);
        idx++;
        hold = 1'b0;
      end else hold = in_valid;
      prev_stall = ov32 && !out_ready;
      pd32 = od32; pd64 = od64; pt = ot32;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rand_recv_count", 64'(recv), 64'(NRAND));

    // Reset with two words in flight.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_op = 3'd0; in_x = '1; in_y = '1; in_z = '0; in_tag = 8'(8'hA0 + c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_full", {63'd0, rdy32}, 64'd0);
    check("pre_rst_valid", {63'd0, ov32}, 64'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_valid", {63'd0, ov32}, 64'd0);
    check("rst_async_valid64", {63'd0, ov64}, 64'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_one("after_rst", 1'b0, 3'd0, 64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 8'h33, 64'h3a6fe667, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
